// File: rtl/nonce_search_ctrl.sv
// Nonce search sequencer: latches a block header and target, launches the hash
// core once per nonce over a start/done handshake, and stops on the first
// digest whose two top bytes are both below the target, or when the nonce
// range runs out.
module nonce_search_ctrl #(
    parameter int          BYTE        = 8,
    parameter int          HASH_W      = 24,
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [31:0] NONCE_MAX   = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [12*BYTE-1:0]   data_in,
    input  logic [7:0]           target,
    output logic                 hash_start,
    output logic [16*BYTE-1:0]   block_out,
    input  logic                 hash_done,
    input  logic [HASH_W-1:0]    hash_in,
    output logic                 busy,
    output logic                 finished,
    output logic                 exhausted,
    output logic [31:0]          nonce_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [12*BYTE-1:0]  data_q, data_d;
    logic [7:0]          target_q, target_d;
    logic [31:0]         nonce_q, nonce_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic                hash_start_q, hash_start_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic                exhausted_q, exhausted_d;
    logic [31:0]         nonce_out_q, nonce_out_d;
    logic                match;

    // Low digest bits are captured for completeness but never compared.
    logic                unused_hash_bits;
    assign unused_hash_bits = ^hash_q;

    // A hit needs both of the two most significant digest bytes strictly below the target.
    assign match = (hash_q[HASH_W-1 -: 8] < target_q) &&
                   (hash_q[HASH_W-9 -: 8] < target_q);

    // Next-state and next-output computation; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        hash_d      = hash_q;
        finished_d  = finished_q;
        exhausted_d = exhausted_q;
        nonce_out_d = nonce_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d      = data_in;
                    target_d    = target;
                    nonce_d     = NONCE_START;
                    finished_d  = 1'b0;
                    exhausted_d = 1'b0;
                    nonce_out_d = '0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                // No timeout: a hash core that never answers keeps us here until reset.
                if (hash_done) begin
                    hash_d  = hash_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match) begin
                    finished_d  = 1'b1;
                    nonce_out_d = nonce_q;
                    state_d     = S_DONE;
                end else if (nonce_q == NONCE_MAX) begin
                    // Last nonce tried; stop rather than wrap.
                    exhausted_d = 1'b1;
                    state_d     = S_FAIL;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = S_LAUNCH;
                end
            end
            S_DONE, S_FAIL: begin
                // Requiring start to drop keeps a held start from relaunching a search.
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        hash_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CHECK);
    end

    // All state and registered outputs; reset aborts any search in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            target_q     <= '0;
            nonce_q      <= NONCE_START;
            hash_q       <= '0;
            hash_start_q <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            exhausted_q  <= 1'b0;
            nonce_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            target_q     <= target_d;
            nonce_q      <= nonce_d;
            hash_q       <= hash_d;
            hash_start_q <= hash_start_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            exhausted_q  <= exhausted_d;
            nonce_out_q  <= nonce_out_d;
        end
    end

    assign block_out  = {data_q, nonce_q};
    assign hash_start = hash_start_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign exhausted  = exhausted_q;
    assign nonce_out  = nonce_out_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench: two controllers (full range and a 0..3 range), each driven
// by a latency-3 hash model that returns per-scenario digests.
module tb_nonce_search_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start2;
    logic [95:0]  data_in;
    logic [7:0]   target;
    logic         hs, hs2;
    logic [127:0] bo, bo2;
    logic         done = 1'b0, done2 = 1'b0;
    logic [23:0]  hin = '0, hin2 = '0;
    logic         busy, busy2, fin, fin2, exh, exh2;
    logic [31:0]  nout, nout2;

    always #5 clk = ~clk;

    nonce_search_ctrl dut (
        .clk(clk), .reset(rst_n), .start(start), .data_in(data_in), .target(target),
        .hash_start(hs), .block_out(bo), .hash_done(done), .hash_in(hin),
        .busy(busy), .finished(fin), .exhausted(exh), .nonce_out(nout)
    );

    nonce_search_ctrl #(.NONCE_START(32'd0), .NONCE_MAX(32'd3)) dut_x (
        .clk(clk), .reset(rst_n), .start(start2), .data_in(data_in), .target(target),
        .hash_start(hs2), .block_out(bo2), .hash_done(done2), .hash_in(hin2),
        .busy(busy2), .finished(fin2), .exhausted(exh2), .nonce_out(nout2)
    );

    int n_chk = 0;
    int n_pass = 0;
    int mode = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    function automatic logic [23:0] digest(input int m, input logic [31:0] n);
        case (m)
            0: return (n == 32'd5) ? 24'h0A0B00 : 24'hFFFFFF;
            2: return (n == 32'd0) ? 24'h100500 : (n == 32'd1) ? 24'h0F0F00 : 24'hFFFFFF;
            3: return (n == 32'd1) ? 24'h202000 : (n == 32'd5) ? 24'h0A0B00 : 24'hFFFFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Hash models: done pulse lands so the DUT sees it 3 edges after sampling hash_start.
    int mc1 = 0;
    logic [31:0] mn1 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin mc1 = 0; done = 1'b0; end
        else if (hs) begin mc1 = 3; mn1 = bo[31:0]; done = 1'b0; end
        else if (mc1 > 0) begin
            mc1--;
            if (mc1 == 0) begin done = 1'b1; hin = digest(mode, mn1); end
        end else done = 1'b0;
    end

    int mc2 = 0;
    always @(negedge clk) begin
        if (!rst_n) begin mc2 = 0; done2 = 1'b0; end
        else if (hs2) begin mc2 = 3; done2 = 1'b0; end
        else if (mc2 > 0) begin
            mc2--;
            if (mc2 == 0) begin done2 = 1'b1; hin2 = 24'hFFFFFF; end
        end else done2 = 1'b0;
    end

    int          pc[$];
    logic [31:0] pn[$];
    logic [95:0] pd[$];
    logic [31:0] pn2[$];
    int          first_fin;

    // Runs ncyc cycles (sampled mid-cycle), logging hash_start pulses of both DUTs.
    task automatic run(input int ncyc, input bit chg);
        pc.delete(); pn.delete(); pd.delete(); pn2.delete();
        first_fin = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (hs) begin pc.push_back(k); pn.push_back(bo[31:0]); pd.push_back(bo[127:32]); end
            if (hs2) pn2.push_back(bo2[31:0]);
            if (fin && first_fin == 0) first_fin = k;
            if (chg && k == 1) begin data_in = '0; target = 8'hFF; end
        end
    endtask

    localparam logic [95:0] D1 = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    localparam logic [95:0] D2 = 96'h1111_2222_3333_4444_5555_6666;

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; data_in = '0; target = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_fin", fin, 0);
        chk("rst_exh", exh, 0);
        chk("rst_nout", nout, 0);
        chk("rst_hs", hs, 0);
        chk("rst_bo", bo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hit at nonce 5 with start held high throughout.
        data_in = D1; target = 8'h10; mode = 0; start = 1'b1;
        run(40, 1'b0);
        chk("hit_npulse", pc.size(), 6);
        if (pc.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("hit_cyc%0d", i), pc[i], 1 + 5 * i);
                chk($sformatf("hit_nonce%0d", i), pn[i], i);
                chk($sformatf("hit_data%0d", i), pd[i], D1);
            end
        chk("hit_fin_cyc", first_fin, 31);
        chk("hit_fin", fin, 1);
        chk("hit_nout", nout, 5);
        chk("hit_busy", busy, 0);
        chk("hit_exh", exh, 0);

        // Start still high after DONE: nothing relaunches.
        run(10, 1'b0);
        chk("hold_npulse", pc.size(), 0);
        chk("hold_fin", fin, 1);
        chk("hold_nout", nout, 5);
        start = 1'b0;
        run(2, 1'b0);
        chk("idle_fin", fin, 1);
        chk("idle_nout", nout, 5);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        run(1, 1'b0);
        chk("restart_fin", fin, 0);
        chk("restart_nout", nout, 0);
        chk("restart_nonce", (pn.size() == 1) ? pn[0] : 32'hFFFF_FFFF, 0);
        start = 1'b0;

        // Reset while waiting on nonce 2's digest.
        run(12, 1'b0);
        chk("rst_mid_npulse", pc.size(), 2);
        chk("rst_mid_nonce", bo[31:0], 2);
        chk("rst_mid_busy0", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hs", hs, 0);
        chk("arst_fin", fin, 0);
        chk("arst_exh", exh, 0);
        chk("arst_nout", nout, 0);
        chk("arst_bo", bo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(10, 1'b0);
        chk("post_rst_npulse", pc.size(), 0);
        chk("post_rst_busy", busy, 0);

        // Strict compare: equal top byte is not a hit.
        data_in = D2; target = 8'h10; mode = 2; start = 1'b1;
        run(20, 1'b0);
        chk("strict_npulse", pc.size(), 2);
        chk("strict_fin_cyc", first_fin, 11);
        chk("strict_nout", nout, 1);
        chk("strict_fin", fin, 1);
        start = 1'b0;
        run(2, 1'b0);

        // Inputs change after acceptance; the latched header and target rule.
        data_in = D1; target = 8'h10; mode = 3; start = 1'b1;
        run(40, 1'b1);
        chk("latch_npulse", pc.size(), 6);
        for (int i = 0; i < pd.size(); i++) chk($sformatf("latch_data%0d", i), pd[i], D1);
        chk("latch_fin_cyc", first_fin, 31);
        chk("latch_nout", nout, 5);
        start = 1'b0;
        run(2, 1'b0);

        // Exhaust on the 0..3 controller.
        start2 = 1'b1;
        run(30, 1'b0);
        chk("exh_npulse", pn2.size(), 4);
        if (pn2.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("exh_nonce%0d", i), pn2[i], i);
        chk("exh_exh", exh2, 1);
        chk("exh_fin", fin2, 0);
        chk("exh_nout", nout2, 0);
        chk("exh_busy", busy2, 0);
        start2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Sequencer for the mining datapath: takes the 12-byte block header and 8-bit target, drives a multi-cycle hash core through a start/done handshake, and steps the 32-bit nonce.
- Each returned hash is compared against the target. The search stops on the first hit (finished, nonce_out) or when the nonce range is exhausted.
- Sits inside sistema, between the top-level inputs and the hash core.

Parameters:
- BYTE, 8, bits per byte; header width is 12*BYTE.
- HASH_W, 24, width of the digest returned by the hash core (must be >= 16).
- NONCE_START, 32'h0000_0000, first nonce tried.
- NONCE_MAX, 32'hFFFF_FFFF, last nonce tried; must be >= NONCE_START.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request; sampled only in IDLE.
- data_in  input  12*BYTE  block header; latched on start acceptance.
- target  input  8  difficulty target; latched on start acceptance.
- hash_start  output  1  one-cycle pulse launching the hash core.
- block_out  output  16*BYTE  {data_reg, nonce} presented to the hash core.
- hash_done  input  1  one-cycle pulse from the hash core, digest valid.
- hash_in  input  HASH_W  digest from the hash core, valid with hash_done.
- busy  output  1  high in LAUNCH/WAIT/CHECK.
- finished  output  1  hit found.
- exhausted  output  1  range searched with no hit.
- nonce_out  output  32  winning nonce, valid while finished=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, nonce=NONCE_START, data_reg=0, target_reg=0, hash_reg=0; all outputs 0.
- IDLE: when start=1, latch data_in→data_reg and target→target_reg, load nonce=NONCE_START, clear finished/exhausted/nonce_out, go to LAUNCH.
- LAUNCH (1 cycle): hash_start=1; go to WAIT.
- WAIT: hold until hash_done=1; on that edge capture hash_in→hash_reg and go to CHECK. There is no timeout.
- CHECK (1 cycle): match = hash_reg[HASH_W-1 -: 8] < target_reg AND hash_reg[HASH_W-9 -: 8] < target_reg (unsigned, strict).
  - match → DONE, finished=1, nonce_out=nonce.
  - no match, nonce==NONCE_MAX → FAIL, exhausted=1.
  - otherwise nonce=nonce+1 → LAUNCH.
- DONE / FAIL: hold flags and nonce_out; return to IDLE only when start=0. Flags persist in IDLE until the next accepted start clears them. Holding start high therefore never relaunches.
- block_out = {data_reg, nonce} combinationally. It is stable from LAUNCH through WAIT; nonce occupies the low 32 bits.
- Throughput: with hash latency L (hash_done L cycles after hash_start), one nonce costs L+2 cycles.
- Nonce never wraps: NONCE_MAX is tried once, then FAIL. With NONCE_START==NONCE_MAX exactly one hash is issued.
- hash_done outside WAIT is ignored. data_in/target changes while busy are ignored.
- finished and exhausted are never both 1.
- Reset mid-search aborts immediately to the reset state. No hash_start is issued until a new start.

Test Plan:
1. Hit. Bench hash model with L=3 returns 24'hFFFFFF except 24'h0A0B00 for nonce 5; target=8'h10; start sampled at edge 0.
   → hash_start pulses at cycles 1, 6, 11, 16, 21, 26.
   → finished=1 and nonce_out=32'h5 from cycle 31; busy=0; exhausted=0.
2. Exhaust. NONCE_START=0, NONCE_MAX=3, model never matches.
   → exactly 4 hash_start pulses with block_out[31:0]=0,1,2,3.
   → exhausted=1, finished=0, nonce_out=0.
3. Strict compare. target=8'h10, digest 24'h10_05_00 for nonce 0 → no hit. Digest 24'h0F_0F_00 for nonce 1 → finished, nonce_out=1.
4. Start held high after DONE. → no further hash_start; flags held. Drop start, raise again → flags clear on acceptance and search restarts at NONCE_START.
5. Reset mid-WAIT: assert reset while nonce=2. → state=IDLE, all outputs 0 asynchronously. After release, no hash_start until start=1.
6. Latching. Change data_in to 96'h0 and target to 8'hFF one cycle after acceptance. → block_out[127:32] still equals the original data_in. Compare uses the original target; same hit nonce as scenario 1.
